// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger sequencer: FSM states, edge-mode
// encodings and default timing parameters.
package trigger_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StRefresh,
    StBlock
  } state_e;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  localparam int unsigned DEFAULT_DEB_TIME      = 10000;
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 10;

endpackage

// File: rtl/edge_qualifier.sv
// Per-channel two-flop synchroniser, edge detector and mode/enable masking.
// qual_o is combinational from registered state and the live mode/enable inputs.
module edge_qualifier
  import trigger_pkg::*;
#(
  parameter int unsigned CHANNELS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] trigger_i,
  input  logic [CHANNELS-1:0] chan_en_i,
  input  logic [1:0]          edge_mode_i,
  output logic [CHANNELS-1:0] qual_o
);

  logic [CHANNELS-1:0] s1_q, s2_q, prev_q;
  logic [CHANNELS-1:0] rise, fall, edges;

  // prev tracks the synchronised level in every FSM state, so a level held
  // while the sequencer is busy cannot fire again once it returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= trigger_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_comb begin
    rise = s2_q & ~prev_q;
    fall = ~s2_q & prev_q;
    case (edge_mode_i)
      EDGE_RISE: edges = rise;
      EDGE_FALL: edges = fall;
      EDGE_BOTH: edges = rise | fall;
      default:   edges = '0;
    endcase
    qual_o = edges & chan_en_i;
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Trigger sequencer: qualified input edge -> increment strobe, settle delay,
// refresh strobe, then a debounce block during which further edges are dropped.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned CHANNELS      = 6,
  parameter int unsigned CNT_WIDTH     = 14,
  parameter int unsigned DEB_TIME      = DEFAULT_DEB_TIME,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] trigger_i,
  input  logic [CHANNELS-1:0] chan_en_i,
  input  logic [1:0]          edge_mode_i,
  output logic                inc_pulse_o,
  output logic [CHANNELS-1:0] inc_vec_o,
  output logic                ref_pulse_o,
  output logic                busy_o,
  output logic                overrun_o
);

  // The counter is already 0 in the inc_pulse cycle, so ending SETTLE at
  // SETTLE_CYCLES leaves exactly SETTLE_CYCLES quiet cycles before ref_pulse.
  localparam logic [CNT_WIDTH-1:0] SettleLast = CNT_WIDTH'(SETTLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DebLast    = CNT_WIDTH'(DEB_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

  logic [CHANNELS-1:0]  qual;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 inc_pulse_q, inc_pulse_d;
  logic                 ref_pulse_q, ref_pulse_d;
  logic                 overrun_q, overrun_d;
  logic [CHANNELS-1:0]  inc_vec_q, inc_vec_d;

  edge_qualifier #(
    .CHANNELS(CHANNELS)
  ) u_edge_qualifier (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger_i  (trigger_i),
    .chan_en_i  (chan_en_i),
    .edge_mode_i(edge_mode_i),
    .qual_o     (qual)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inc_pulse_d = 1'b0;
    ref_pulse_d = 1'b0;
    inc_vec_d   = inc_vec_q;
    overrun_d   = (state_q != StIdle) && (|qual);
    unique case (state_q)
      StIdle: begin
        if (|qual) begin
          inc_pulse_d = 1'b1;
          inc_vec_d   = qual;
          cnt_d       = '0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          ref_pulse_d = 1'b1;
          state_d     = StRefresh;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRefresh: begin
        cnt_d   = '0;
        state_d = StBlock;
      end
      StBlock: begin
        if (cnt_q == DebLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      inc_pulse_q <= 1'b0;
      ref_pulse_q <= 1'b0;
      overrun_q   <= 1'b0;
      inc_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inc_pulse_q <= inc_pulse_d;
      ref_pulse_q <= ref_pulse_d;
      overrun_q   <= overrun_d;
      inc_vec_q   <= inc_vec_d;
    end
  end

  assign inc_pulse_o = inc_pulse_q;
  assign ref_pulse_o = ref_pulse_q;
  assign overrun_o   = overrun_q;
  assign inc_vec_o   = inc_vec_q;
  assign busy_o      = (state_q != StIdle);

endmodule
